// File: rtl/delay_meter.sv
// delay_meter: measures the number of enabled cycles from a start strobe
// (exclusive) to a stop strobe (inclusive). The result is held until acked,
// and the block keeps sticky min/max statistics and an overrun flag.
module delay_meter #(
  parameter int unsigned           CNT_W   = 16,
  parameter logic [CNT_W-1:0]      MAX_CNT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             meas_ack,
  input  logic             clr_stats,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_timeout,
  output logic             busy,
  output logic             overrun,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_meas_count, w_meas_count_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic [CNT_W-1:0] r_min, w_min_nxt;
  logic [CNT_W-1:0] r_max, w_max_nxt;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_fold;
  logic [CNT_W-1:0] w_result;

  // State and result registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_meas_count <= '0;
      r_timeout    <= 1'b0;
      r_overrun    <= 1'b0;
      r_min        <= '1;
      r_max        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_meas_count <= w_meas_count_nxt;
      r_timeout    <= w_timeout_nxt;
      r_overrun    <= w_overrun_nxt;
      r_min        <= w_min_nxt;
      r_max        <= w_max_nxt;
    end
  end

  // Next-state, counter, result capture, overrun and statistics logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_meas_count_nxt = r_meas_count;
    w_timeout_nxt    = r_timeout;
    w_overrun_nxt    = r_overrun;
    w_min_nxt        = r_min;
    w_max_nxt        = r_max;
    w_fold           = 1'b0;
    w_result         = '0;
    w_cnt_inc        = r_cnt + CNT_W'(1);

    unique case (r_state)
      S_IDLE: begin
        if (enable && start) begin
          if (stop) begin
            w_state_nxt      = S_HOLD;
            w_meas_count_nxt = '0;
            w_timeout_nxt    = 1'b0;
            w_fold           = 1'b1;
            w_result         = '0;
          end else begin
            w_state_nxt = S_COUNT;
            w_cnt_nxt   = '0;
          end
        end
      end

      S_COUNT: begin
        if (enable) begin
          if (start) begin
            w_overrun_nxt = 1'b1;
          end
          if (stop) begin
            w_state_nxt      = S_HOLD;
            w_meas_count_nxt = w_cnt_inc;
            w_timeout_nxt    = 1'b0;
            w_fold           = 1'b1;
            w_result         = w_cnt_inc;
          end else if (w_cnt_inc == MAX_CNT) begin
            w_state_nxt      = S_HOLD;
            w_meas_count_nxt = MAX_CNT;
            w_timeout_nxt    = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end

      S_HOLD: begin
        // ack is honoured regardless of enable; a start only counts when enabled
        if (meas_ack) begin
          if (enable && start) begin
            w_state_nxt = S_COUNT;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (enable && start) begin
          w_overrun_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_fold) begin
      if (w_result < r_min) begin
        w_min_nxt = w_result;
      end
      if (w_result > r_max) begin
        w_max_nxt = w_result;
      end
    end

    // clear wins over a result folded in on the same edge
    if (clr_stats) begin
      w_min_nxt     = '1;
      w_max_nxt     = '0;
      w_overrun_nxt = 1'b0;
    end
  end

  assign meas_valid   = (r_state == S_HOLD);
  assign busy         = (r_state == S_COUNT);
  assign meas_count   = r_meas_count;
  assign meas_timeout = r_timeout;
  assign overrun      = r_overrun;
  assign min_count    = r_min;
  assign max_count    = r_max;

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter: two instances (16-bit and 4-bit counters) share one
// stimulus stream and are checked every cycle against a timestamp-based model.
module tb_delay_meter;

  logic        clk;
  logic        rst;
  logic        enable, start, stop, meas_ack, clr_stats;

  logic        v16, to16, b16, ov16;
  logic [15:0] c16, mn16, mx16;
  logic        v4, to4, b4, ov4;
  logic [3:0]  c4, mn4, mx4;

  int unsigned n_cmp;
  int unsigned n_bad;

  delay_meter u_dut16 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .meas_ack(meas_ack), .clr_stats(clr_stats),
    .meas_valid(v16), .meas_count(c16), .meas_timeout(to16), .busy(b16),
    .overrun(ov16), .min_count(mn16), .max_count(mx16)
  );

  delay_meter #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop),
    .meas_ack(meas_ack), .clr_stats(clr_stats),
    .meas_valid(v4), .meas_count(c4), .meas_timeout(to4), .busy(b4),
    .overrun(ov4), .min_count(mn4), .max_count(mx4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Latency = (enabled-cycle index of stop) - (enabled-cycle index of start).
  int unsigned e_idx;
  int unsigned MAXV [2] = '{65535, 15};
  bit          m_valid [2];
  bit          m_busy  [2];
  bit          m_to    [2];
  bit          m_ovr   [2];
  int unsigned m_count [2];
  int unsigned m_min   [2];
  int unsigned m_max   [2];
  int unsigned m_st    [2];

  task automatic m_close(input int k, input int unsigned v, input bit t);
    m_busy[k]  = 1'b0;
    m_valid[k] = 1'b1;
    m_count[k] = v;
    m_to[k]    = t;
    if (!t) begin
      if (v < m_min[k]) m_min[k] = v;
      if (v > m_max[k]) m_max[k] = v;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_idx = 0;
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 1'b0; m_busy[k] = 1'b0; m_to[k] = 1'b0; m_ovr[k] = 1'b0;
        m_count[k] = 0; m_min[k] = MAXV[k]; m_max[k] = 0; m_st[k] = 0;
      end
    end else begin
      if (enable) e_idx++;
      for (int k = 0; k < 2; k++) begin
        if (m_valid[k]) begin
          if (meas_ack) begin
            m_valid[k] = 1'b0;
            if (enable && start) begin
              m_busy[k] = 1'b1;
              m_st[k]   = e_idx;
            end
          end else if (enable && start) begin
            m_ovr[k] = 1'b1;
          end
        end else if (m_busy[k]) begin
          if (enable) begin
            if (start) m_ovr[k] = 1'b1;
            if (stop) m_close(k, e_idx - m_st[k], 1'b0);
            else if (e_idx - m_st[k] == MAXV[k]) m_close(k, MAXV[k], 1'b1);
          end
        end else if (enable && start) begin
          if (stop) m_close(k, 0, 1'b0);
          else begin
            m_busy[k] = 1'b1;
            m_st[k]   = e_idx;
          end
        end
        if (clr_stats) begin
          m_min[k] = MAXV[k];
          m_max[k] = 0;
          m_ovr[k] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("u16.valid",   v16,  m_valid[0]);
    chk("u16.busy",    b16,  m_busy[0]);
    chk("u16.count",   c16,  m_count[0]);
    chk("u16.timeout", to16, m_to[0]);
    chk("u16.overrun", ov16, m_ovr[0]);
    chk("u16.min",     mn16, m_min[0]);
    chk("u16.max",     mx16, m_max[0]);
    chk("u4.valid",    v4,   m_valid[1]);
    chk("u4.busy",     b4,   m_busy[1]);
    chk("u4.count",    c4,   m_count[1]);
    chk("u4.timeout",  to4,  m_to[1]);
    chk("u4.overrun",  ov4,  m_ovr[1]);
    chk("u4.min",      mn4,  m_min[1]);
    chk("u4.max",      mx4,  m_max[1]);
  end

  // Drive one clock of inputs; returns 1 time unit after the edge.
  task automatic step(input bit e, input bit s, input bit p, input bit a, input bit c);
    enable = e; start = s; stop = p; meas_ack = a; clr_stats = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    enable = 0; start = 0; stop = 0; meas_ack = 0; clr_stats = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.valid", v16, 0);
    chk("rst.min",   mn16, 16'hFFFF);
    chk("rst.max",   mx16, 0);
    rst = 1'b1;
    step(1, 0, 0, 0, 0);

    // basic 100-cycle measurement
    step(1, 1, 0, 0, 0);
    repeat (99) step(1, 0, 0, 0, 0);
    chk("lat100.notyet", v16, 0);
    step(1, 0, 1, 0, 0);
    chk("lat100.valid", v16, 1);
    chk("lat100.count", c16, 100);
    chk("lat100.to",    to16, 0);
    chk("lat100.min",   mn16, 100);
    chk("lat100.max",   mx16, 100);
    step(1, 0, 0, 1, 0);
    chk("ack.valid", v16, 0);

    // start and stop together, then stop alone
    step(1, 1, 1, 0, 0);
    chk("zero.valid", v16, 1);
    chk("zero.count", c16, 0);
    chk("zero.min",   mn16, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    chk("stopalone.busy",  b16, 0);
    chk("stopalone.valid", v16, 0);

    // enable toggling: stop 40 clocks after start, 20 of them enabled
    step(1, 1, 0, 0, 0);
    for (int i = 1; i < 40; i++) step((i % 2) == 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("toggle.count", c16, 20);
    chk("toggle.valid", v16, 1);
    step(1, 0, 0, 1, 0);

    // timeout on the 4-bit instance
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0);
    repeat (14) step(1, 0, 0, 0, 0);
    chk("to4.notyet", v4, 0);
    chk("to4.busy",   b4, 1);
    step(1, 0, 0, 0, 0);
    chk("to4.valid", v4, 1);
    chk("to4.count", c4, 15);
    chk("to4.flag",  to4, 1);
    chk("to4.min",   mn4, 15);
    chk("to4.max",   mx4, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);

    // overrun in COUNT and in HOLD, clear, then ack+start
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("ovr.count.flag", ov16, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("ovr.count", c16, 3);
    step(1, 1, 0, 0, 0);
    chk("ovr.hold.valid", v16, 1);
    chk("ovr.hold.count", c16, 3);
    chk("ovr.hold.flag",  ov16, 1);
    step(1, 0, 0, 0, 1);
    chk("clr.ovr", ov16, 0);
    chk("clr.min", mn16, 16'hFFFF);
    chk("clr.max", mx16, 0);
    step(1, 1, 0, 1, 0);
    chk("ackstart.valid", v16, 0);
    chk("ackstart.busy",  b16, 1);
    chk("ackstart.ovr",   ov16, 0);
    step(1, 0, 1, 0, 0);
    chk("ackstart.count", c16, 1);
    step(1, 0, 0, 1, 0);

    // asynchronous reset in the middle of a measurement
    step(1, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    chk("arst.busy",  b16, 0);
    chk("arst.valid", v16, 0);
    chk("arst.count", c16, 0);
    chk("arst.min",   mn16, 16'hFFFF);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1, 1, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("arst.next.count", c16, 5);
    step(1, 0, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 63) == 0);
    end
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_meter.md
Name: delay_meter

Overview:
- Measures the latency between a start strobe and a stop strobe, counted in enable-qualified clock cycles.
- It is the counterpart of the delayed-strobe generator: that block produces a pulse N enabled cycles after its trigger, and this block takes the two pulses and reports N.
- Used in the Viterbi datapath to check encoder-to-decoder and traceback latency on the board.
- Results are returned through a valid/ack holding register, with sticky min/max statistics.

Parameters:
- CNT_W, 16, width of the counter and of all result fields.
- MAX_CNT, 2**CNT_W-1, timeout value; a measurement that reaches this count without a stop is closed as a timeout.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- enable  in  1  cycle qualifier; the counter and FSM advance only when it is 1.
- start  in  1  single-cycle start strobe.
- stop  in  1  single-cycle stop strobe.
- meas_ack  in  1  consumer acknowledge for the held result.
- clr_stats  in  1  synchronous clear of min_count, max_count and overrun.
- meas_valid  out  1  result held and available.
- meas_count  out  CNT_W  measured latency.
- meas_timeout  out  1  set when the result is a timeout.
- busy  out  1  1 while in COUNT.
- overrun  out  1  sticky; a start was lost.
- min_count  out  CNT_W  smallest non-timeout result since the last clear.
- max_count  out  CNT_W  largest non-timeout result since the last clear.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0.
  - meas_valid=0, meas_count=0, meas_timeout=0, busy=0, overrun=0.
  - min_count=all ones, max_count=0.
- Definition of latency: the number of enabled cycles after the start cycle (exclusive) up to and including the stop cycle.
- enable=0:
  - state, cnt, start and stop are frozen or ignored.
  - meas_ack and clr_stats still take effect.
- States:
  - IDLE:
    - start&enable&!stop -> COUNT, cnt=0.
    - start&stop&enable -> HOLD, meas_count=0.
    - stop alone is ignored.
  - COUNT:
    - busy=1.
    - Each enabled cycle with stop=1 -> HOLD, meas_count=cnt+1, meas_timeout=0.
    - Else, if cnt+1==MAX_CNT -> HOLD, meas_count=MAX_CNT, meas_timeout=1.
    - Else cnt=cnt+1.
    - start in COUNT (enabled) sets overrun and does not restart; if stop is also asserted, the stop is still honoured.
  - HOLD:
    - meas_valid=1; meas_count and meas_timeout are stable until acked.
    - meas_ack=1 -> meas_valid=0 next cycle; state -> IDLE, unless start&enable in the same cycle, in which case -> COUNT with cnt=0 and no overrun.
    - start without ack sets overrun and is dropped.
    - meas_ack while meas_valid=0 is ignored.
- Latency of the result: meas_valid rises on the clock edge that samples stop, so it is visible the cycle after stop.
- Stats:
  - Updated on the edge entering HOLD, only when meas_timeout=0.
  - min_count=min(min_count, result) and max_count=max(max_count, result).
  - clr_stats has priority over a simultaneous update: all values go to reset values and the new result is not folded in.
  - Stats are unsigned compares over the full CNT_W width.
- Reset mid-operation: the measurement is lost, and the block returns to the reset state immediately.

Test Plan:
- enable=1; start at cycle 10, stop at cycle 110 -> meas_valid=1 at cycle 111, meas_count=100, meas_timeout=0, min_count=max_count=100.
- Start and stop in the same cycle -> meas_count=0, meas_valid=1 next cycle; stop alone in IDLE -> no result, busy stays 0.
- enable toggling 1/0 every cycle; start, then stop 40 clock cycles later (start and stop both on enabled cycles) -> meas_count=20, with cnt frozen on disabled cycles.
- CNT_W=4, start with no stop -> meas_count=15, meas_timeout=1 after 15 enabled cycles; min_count and max_count unchanged.
- Extra start during COUNT and during HOLD without ack -> overrun=1, first measurement unaffected. start together with ack in HOLD -> new measurement begins with no overrun. clr_stats -> overrun=0, min_count=all ones, max_count=0.
- rst pulsed low mid-COUNT -> all outputs take reset values asynchronously; the next start/stop pair of 5 cycles -> meas_count=5.
